fse_lms_cplx: RTL and testbench

- Complex fractionally-spaced equalizer (FSE) with integrated LMS tap adaptation, pipelined multiply-accumulate, sample-valid handshake and symbol-rate decimated output.
- Sits between the rx matched filter / downsampler (OS_FACTOR samples per symbol) and the slicer.
- The slicer computes the error and returns it for in-block coefficient update.
- External tap load is kept for initialisation and debug override.

---
 rtl/fse_pkg.sv | 42 ++++
 rtl/fse_lms_tap_update.sv | 52 +++++
 rtl/fse_lms_cplx.sv | 210 +++++++++++++++++++++
 tb/tb_fse_lms_cplx.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fse_pkg.sv
// Shared formats, derived-width helpers and the common saturate/truncate
// routine used by both the equalizer output and the coefficient update paths.
package fse_pkg;

  localparam int NUM_TAPS_D  = 9;
  localparam int OS_FACTOR_D = 2;
  localparam int NBT_IN_D    = 8;
  localparam int NBF_IN_D    = 7;
  localparam int NBT_TAPS_D  = 10;
  localparam int NBF_TAPS_D  = 7;
  localparam int NB_GUARD_D  = 7;
  localparam int NBT_ERR_D   = 8;
  localparam int NBF_ERR_D   = 7;
  localparam int NBT_OUT_D   = 12;
  localparam int NBF_OUT_D   = 9;
  localparam int NB_MU_D     = 4;

  function automatic int coef_width(input int nbt_taps, input int nb_guard);
    return nbt_taps + nb_guard;
  endfunction

  function automatic int acc_width(input int nbt_in, input int nbt_taps, input int num_taps);
    return nbt_in + nbt_taps + $clog2(num_taps) + 1;
  endfunction

  // Drop (nbf_in - nbf_out) fraction bits with floor, then clamp to nbt_out bits.
  function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] v,
                                                   input int nbf_in,
                                                   input int nbt_out,
                                                   input int nbf_out);
    logic signed [63:0] t;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    t  = v >>> (nbf_in - nbf_out);
    hi = (64'sd1 <<< (nbt_out - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (t > hi) return hi;
    if (t < lo) return lo;
    return t;
  endfunction

endpackage

// File: rtl/fse_lms_tap_update.sv
// One complex tap of the LMS update: g = e*conj(s), align, scale by 2^-mu,
// subtract from the stored coefficient and saturate.
module fse_lms_tap_update
  import fse_pkg::*;
#(
  parameter int NBT_IN   = NBT_IN_D,
  parameter int NBF_IN   = NBF_IN_D,
  parameter int NBT_ERR  = NBT_ERR_D,
  parameter int NBF_ERR  = NBF_ERR_D,
  parameter int NBT_COEF = coef_width(NBT_TAPS_D, NB_GUARD_D),
  parameter int NBF_COEF = NBF_TAPS_D + NB_GUARD_D,
  parameter int NB_MU    = NB_MU_D
) (
  input  logic signed [NBT_COEF-1:0] coef_I,
  input  logic signed [NBT_COEF-1:0] coef_Q,
  input  logic signed [NBT_ERR-1:0]  err_I,
  input  logic signed [NBT_ERR-1:0]  err_Q,
  input  logic signed [NBT_IN-1:0]   snap_I,
  input  logic signed [NBT_IN-1:0]   snap_Q,
  input  logic        [NB_MU-1:0]    mu_shift,
  output logic signed [NBT_COEF-1:0] coef_nxt_I,
  output logic signed [NBT_COEF-1:0] coef_nxt_Q
);

  localparam int NB_P  = NBT_ERR + NBT_IN;
  localparam int NB_G  = NB_P + 1;
  localparam int ALIGN = NBF_ERR + NBF_IN - NBF_COEF;
  localparam int NB_D  = ((NB_G > NBT_COEF) ? NB_G : NBT_COEF) + 1;

  if (ALIGN < 0) begin : g_align_chk
    $error("fse_lms_tap_update: error/sample fraction bits must cover NBF_COEF");
  end

  logic signed [NB_G-1:0] g_I;
  logic signed [NB_G-1:0] g_Q;
  logic signed [NB_G-1:0] step_I;
  logic signed [NB_G-1:0] step_Q;
  logic signed [NB_D-1:0] diff_I;
  logic signed [NB_D-1:0] diff_Q;

  always_comb begin
    g_I = NB_G'(NB_P'(err_I) * NB_P'(snap_I)) + NB_G'(NB_P'(err_Q) * NB_P'(snap_Q));
    g_Q = NB_G'(NB_P'(err_Q) * NB_P'(snap_I)) - NB_G'(NB_P'(err_I) * NB_P'(snap_Q));
    step_I = (g_I >>> ALIGN) >>> mu_shift;
    step_Q = (g_Q >>> ALIGN) >>> mu_shift;
    diff_I = NB_D'(coef_I) - NB_D'(step_I);
    diff_Q = NB_D'(coef_Q) - NB_D'(step_Q);
    coef_nxt_I = NBT_COEF'(sat_trunc(64'(diff_I), 0, NBT_COEF, 0));
    coef_nxt_Q = NBT_COEF'(sat_trunc(64'(diff_Q), 0, NBT_COEF, 0));
  end

endmodule

// File: rtl/fse_lms_cplx.sv
// Complex fractionally-spaced equalizer with in-block LMS adaptation and
// symbol-rate output (3-cycle latency from a symbol sample to o_valid).
module fse_lms_cplx
  import fse_pkg::*;
#(
  parameter int NUM_TAPS  = NUM_TAPS_D,
  parameter int OS_FACTOR = OS_FACTOR_D,
  parameter int NBT_IN    = NBT_IN_D,
  parameter int NBF_IN    = NBF_IN_D,
  parameter int NBT_TAPS  = NBT_TAPS_D,
  parameter int NBF_TAPS  = NBF_TAPS_D,
  parameter int NB_GUARD  = NB_GUARD_D,
  parameter int NBT_ERR   = NBT_ERR_D,
  parameter int NBF_ERR   = NBF_ERR_D,
  parameter int NBT_OUT   = NBT_OUT_D,
  parameter int NBF_OUT   = NBF_OUT_D,
  parameter int NB_MU     = NB_MU_D
) (
  input  logic                         clk,
  input  logic                         i_reset_n,
  input  logic                         i_en_rx,
  input  logic                         i_valid,
  input  logic signed [NBT_IN-1:0]     i_data_I,
  input  logic signed [NBT_IN-1:0]     i_data_Q,
  output logic                         o_valid,
  output logic signed [NBT_OUT-1:0]    o_data_I,
  output logic signed [NBT_OUT-1:0]    o_data_Q,
  input  logic                         i_err_valid,
  input  logic signed [NBT_ERR-1:0]    i_err_I,
  input  logic signed [NBT_ERR-1:0]    i_err_Q,
  input  logic                         i_adapt_en,
  input  logic        [NB_MU-1:0]      i_mu_shift,
  input  logic                         i_taps_load,
  input  logic [NUM_TAPS*NBT_TAPS-1:0] i_taps_I,
  input  logic [NUM_TAPS*NBT_TAPS-1:0] i_taps_Q,
  output logic [NUM_TAPS*NBT_TAPS-1:0] o_taps_I,
  output logic [NUM_TAPS*NBT_TAPS-1:0] o_taps_Q
);

  localparam int MID      = NUM_TAPS / 2;
  localparam int NBT_COEF = coef_width(NBT_TAPS, NB_GUARD);
  localparam int NBF_COEF = NBF_TAPS + NB_GUARD;
  localparam int NB_PROD  = NBT_IN + NBT_TAPS;
  localparam int NB_ACC   = acc_width(NBT_IN, NBT_TAPS, NUM_TAPS);
  localparam int NB_PH    = (OS_FACTOR > 1) ? $clog2(OS_FACTOR) : 1;
  localparam logic signed [NBT_COEF-1:0] COEF_ONE =
    {{(NBT_COEF-NBF_COEF-1){1'b0}}, 1'b1, {NBF_COEF{1'b0}}};

  if (OS_FACTOR < 1) begin : g_os_chk
    $error("fse_lms_cplx: OS_FACTOR must be at least 1");
  end

  logic signed [NBT_IN-1:0]   sh_I   [NUM_TAPS];
  logic signed [NBT_IN-1:0]   sh_Q   [NUM_TAPS];
  logic signed [NBT_IN-1:0]   snap_I [NUM_TAPS];
  logic signed [NBT_IN-1:0]   snap_Q [NUM_TAPS];
  logic signed [NB_PROD-1:0]  p_ii   [NUM_TAPS];
  logic signed [NB_PROD-1:0]  p_qq   [NUM_TAPS];
  logic signed [NB_PROD-1:0]  p_iq   [NUM_TAPS];
  logic signed [NB_PROD-1:0]  p_qi   [NUM_TAPS];
  logic signed [NBT_COEF-1:0] coef_I [NUM_TAPS];
  logic signed [NBT_COEF-1:0] coef_Q [NUM_TAPS];
  logic signed [NBT_COEF-1:0] coef_nxt_I [NUM_TAPS];
  logic signed [NBT_COEF-1:0] coef_nxt_Q [NUM_TAPS];
  logic signed [NBT_TAPS-1:0] w_I    [NUM_TAPS];
  logic signed [NBT_TAPS-1:0] w_Q    [NUM_TAPS];

  logic [NB_PH-1:0]           phase;
  logic                       last_ph;
  logic                       sym_p1;
  logic                       sym_p2;
  logic signed [NB_ACC-1:0]   acc_I;
  logic signed [NB_ACC-1:0]   acc_Q;
  logic signed [NBT_OUT-1:0]  y_sat_I;
  logic signed [NBT_OUT-1:0]  y_sat_Q;

  assign last_ph = (phase == NB_PH'(OS_FACTOR - 1));

  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
    assign w_I[k] = coef_I[k][NBT_COEF-1 -: NBT_TAPS];
    assign w_Q[k] = coef_Q[k][NBT_COEF-1 -: NBT_TAPS];
    assign o_taps_I[k*NBT_TAPS +: NBT_TAPS] = w_I[k];
    assign o_taps_Q[k*NBT_TAPS +: NBT_TAPS] = w_Q[k];

    fse_lms_tap_update #(
      .NBT_IN   (NBT_IN),
      .NBF_IN   (NBF_IN),
      .NBT_ERR  (NBT_ERR),
      .NBF_ERR  (NBF_ERR),
      .NBT_COEF (NBT_COEF),
      .NBF_COEF (NBF_COEF),
      .NB_MU    (NB_MU)
    ) u_upd (
      .coef_I     (coef_I[k]),
      .coef_Q     (coef_Q[k]),
      .err_I      (i_err_I),
      .err_Q      (i_err_Q),
      .snap_I     (snap_I[k]),
      .snap_Q     (snap_Q[k]),
      .mu_shift   (i_mu_shift),
      .coef_nxt_I (coef_nxt_I[k]),
      .coef_nxt_Q (coef_nxt_Q[k])
    );
  end

  // Full-precision adder tree, then truncate/saturate to the output format.
  always_comb begin
    acc_I = '0;
    acc_Q = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      acc_I = acc_I + NB_ACC'(p_ii[k]) - NB_ACC'(p_qq[k]);
      acc_Q = acc_Q + NB_ACC'(p_iq[k]) + NB_ACC'(p_qi[k]);
    end
    y_sat_I = NBT_OUT'(sat_trunc(64'(acc_I), NBF_IN + NBF_TAPS, NBT_OUT, NBF_OUT));
    y_sat_Q = NBT_OUT'(sat_trunc(64'(acc_Q), NBF_IN + NBF_TAPS, NBT_OUT, NBF_OUT));
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        sh_I[k]   <= '0;
        sh_Q[k]   <= '0;
        snap_I[k] <= '0;
        snap_Q[k] <= '0;
        p_ii[k]   <= '0;
        p_qq[k]   <= '0;
        p_iq[k]   <= '0;
        p_qi[k]   <= '0;
      end
      phase    <= '0;
      sym_p1   <= 1'b0;
      sym_p2   <= 1'b0;
      o_valid  <= 1'b0;
      o_data_I <= '0;
      o_data_Q <= '0;
    end else if (!i_en_rx) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        sh_I[k]   <= '0;
        sh_Q[k]   <= '0;
        snap_I[k] <= '0;
        snap_Q[k] <= '0;
        p_ii[k]   <= '0;
        p_qq[k]   <= '0;
        p_iq[k]   <= '0;
        p_qi[k]   <= '0;
      end
      phase    <= '0;
      sym_p1   <= 1'b0;
      sym_p2   <= 1'b0;
      o_valid  <= 1'b0;
      o_data_I <= '0;
      o_data_Q <= '0;
    end else begin
      sym_p1 <= 1'b0;
      if (i_valid) begin
        sh_I[0] <= i_data_I;
        sh_Q[0] <= i_data_Q;
        for (int k = 1; k < NUM_TAPS; k++) begin
          sh_I[k] <= sh_I[k-1];
          sh_Q[k] <= sh_Q[k-1];
        end
        phase  <= last_ph ? '0 : phase + 1'b1;
        sym_p1 <= last_ph;
      end
      // Products and the LMS snapshot see the same shifter contents.
      if (sym_p1) begin
        for (int k = 0; k < NUM_TAPS; k++) begin
          p_ii[k]   <= NB_PROD'(sh_I[k]) * NB_PROD'(w_I[k]);
          p_qq[k]   <= NB_PROD'(sh_Q[k]) * NB_PROD'(w_Q[k]);
          p_iq[k]   <= NB_PROD'(sh_I[k]) * NB_PROD'(w_Q[k]);
          p_qi[k]   <= NB_PROD'(sh_Q[k]) * NB_PROD'(w_I[k]);
          snap_I[k] <= sh_I[k];
          snap_Q[k] <= sh_Q[k];
        end
      end
      sym_p2  <= sym_p1;
      o_valid <= sym_p2;
      if (sym_p2) begin
        o_data_I <= y_sat_I;
        o_data_Q <= y_sat_Q;
      end
    end
  end

  // Tap load wins over adaptation; loaded taps start with clear guard bits.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        coef_I[k] <= (k == MID) ? COEF_ONE : '0;
        coef_Q[k] <= '0;
      end
    end else if (!i_en_rx) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        coef_I[k] <= (k == MID) ? COEF_ONE : '0;
        coef_Q[k] <= '0;
      end
    end else if (i_taps_load) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        coef_I[k] <= {i_taps_I[k*NBT_TAPS +: NBT_TAPS], {NB_GUARD{1'b0}}};
        coef_Q[k] <= {i_taps_Q[k*NBT_TAPS +: NBT_TAPS], {NB_GUARD{1'b0}}};
      end
    end else if (i_err_valid && i_adapt_en) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        coef_I[k] <= coef_nxt_I[k];
        coef_Q[k] <= coef_nxt_Q[k];
      end
    end
  end

endmodule

// File: tb/tb_fse_lms_cplx.sv
// Self-checking bench for fse_lms_cplx: vector table plus hand-written
// sequences, with a cycle-stamped scoreboard of expected output symbols.
module tb_fse_lms_cplx;

  localparam int NT  = 9;
  localparam int MID = 4;
  localparam int OS  = 2;
  localparam int TW  = 10;

  logic          clk = 1'b0;
  logic          i_reset_n;
  logic          i_en_rx;
  logic          i_valid;
  logic [7:0]    i_data_I, i_data_Q;
  logic          o_valid;
  logic [11:0]   o_data_I, o_data_Q;
  logic          i_err_valid;
  logic [7:0]    i_err_I, i_err_Q;
  logic          i_adapt_en;
  logic [3:0]    i_mu_shift;
  logic          i_taps_load;
  logic [NT*TW-1:0] i_taps_I, i_taps_Q, o_taps_I, o_taps_Q;

  always #5 clk = ~clk;

  fse_lms_cplx dut (
    .clk         (clk),
    .i_reset_n   (i_reset_n),
    .i_en_rx     (i_en_rx),
    .i_valid     (i_valid),
    .i_data_I    (i_data_I),
    .i_data_Q    (i_data_Q),
    .o_valid     (o_valid),
    .o_data_I    (o_data_I),
    .o_data_Q    (o_data_Q),
    .i_err_valid (i_err_valid),
    .i_err_I     (i_err_I),
    .i_err_Q     (i_err_Q),
    .i_adapt_en  (i_adapt_en),
    .i_mu_shift  (i_mu_shift),
    .i_taps_load (i_taps_load),
    .i_taps_I    (i_taps_I),
    .i_taps_Q    (i_taps_Q),
    .o_taps_I    (o_taps_I),
    .o_taps_Q    (o_taps_Q)
  );

  typedef struct {
    logic        chk;
    logic [11:0] ei;
    logic [11:0] eq;
    int          cyc;
  } sb_t;

  typedef struct {
    logic [9:0]  t_all;
    logic [9:0]  t_mid_i;
    logic [9:0]  t_mid_q;
    logic [7:0]  xi;
    logic [7:0]  xq;
    logic [11:0] ei;
    logic [11:0] eq;
  } vec_t;

  sb_t  sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   ph    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [NT*TW-1:0] act, input logic [NT*TW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Pop one expected symbol per o_valid and check its cycle and data.
  always @(negedge clk) begin
    sb_t e;
    if (i_reset_n === 1'b1 && o_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_o_valid: got o_valid=1 with no symbol pending (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("o_valid_cycle", (NT*TW)'(cyc), (NT*TW)'(e.cyc));
        if (e.chk) begin
          check("o_data_I", (NT*TW)'(o_data_I), (NT*TW)'(e.ei));
          check("o_data_Q", (NT*TW)'(o_data_Q), (NT*TW)'(e.eq));
        end
      end
    end
  end

  function automatic logic [NT*TW-1:0] one_tap(input int k, input logic [9:0] v);
    logic [NT*TW-1:0] r;
    r = '0;
    r[k*TW +: TW] = v;
    return r;
  endfunction

  task automatic send(input logic [7:0] xi, input logic [7:0] xq, input logic c,
                      input logic [11:0] ei, input logic [11:0] eq);
    sb_t e;
    @(posedge clk); #1;
    i_valid  = 1'b1;
    i_data_I = xi;
    i_data_Q = xq;
    if (ph == OS - 1) begin
      e.chk = c; e.ei = ei; e.eq = eq; e.cyc = cyc + 3;
      sb.push_back(e);
    end
    ph = (ph == OS - 1) ? 0 : ph + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      i_valid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    check("drain_pending", (NT*TW)'(sb.size()), '0);
  endtask

  task automatic do_reset();
    i_reset_n = 1'b0; i_en_rx = 1'b1; i_valid = 1'b0;
    i_data_I = '0; i_data_Q = '0;
    i_err_valid = 1'b0; i_err_I = '0; i_err_Q = '0;
    i_adapt_en = 1'b0; i_mu_shift = '0; i_taps_load = 1'b0;
    i_taps_I = '0; i_taps_Q = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    i_reset_n = 1'b1;
    ph = 0;
    sb.delete();
  endtask

  task automatic soft_clear();
    @(posedge clk); #1;
    i_valid = 1'b0; i_en_rx = 1'b0;
    @(posedge clk); #1;
    i_en_rx = 1'b1;
    ph = 0;
  endtask

  task automatic load(input logic [NT*TW-1:0] ti, input logic [NT*TW-1:0] tq, input logic with_err);
    @(posedge clk); #1;
    i_valid = 1'b0; i_taps_load = 1'b1; i_taps_I = ti; i_taps_Q = tq;
    i_err_valid = with_err; i_adapt_en = with_err;
    @(posedge clk); #1;
    i_taps_load = 1'b0; i_err_valid = 1'b0;
  endtask

  task automatic err_upd(input logic [7:0] ei, input logic [7:0] eq, input logic [3:0] mu, input logic adapt);
    @(posedge clk); #1;
    i_valid = 1'b0; i_err_valid = 1'b1; i_err_I = ei; i_err_Q = eq;
    i_mu_shift = mu; i_adapt_en = adapt;
    @(posedge clk); #1;
    i_err_valid = 1'b0;
  endtask

  // Samples 0, 0x40, 0...; the impulse reaches the centre tap on sample 5.
  task automatic impulse(input int n);
    for (int j = 0; j < n; j++)
      send((j == 1) ? 8'h40 : 8'h00, 8'h00, 1'b1, (j == 5) ? 12'h100 : 12'h000, 12'h000);
    idle(1);
    drain();
  endtask

  vec_t            vt[12];
  logic [NT*TW-1:0] ti, tq;
  logic [7:0]      hist_I[$], hist_Q[$];
  logic [7:0]      xi, xq;
  logic [11:0]     ei, eq;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{10'h080, 10'h080, 10'h000, 8'h7F, 8'h00, 12'h7FF, 12'h000};
    vt[1]  = '{10'h080, 10'h080, 10'h000, 8'h80, 8'h00, 12'h800, 12'h000};
    vt[2]  = '{10'h000, 10'h000, 10'h080, 8'h40, 8'h00, 12'h000, 12'h100};
    vt[3]  = '{10'h000, 10'h000, 10'h080, 8'h00, 8'h40, 12'hF00, 12'h000};
    vt[4]  = '{10'h000, 10'h080, 10'h000, 8'h40, 8'h20, 12'h100, 12'h080};
    vt[5]  = '{10'h040, 10'h040, 10'h000, 8'h20, 8'h00, 12'h240, 12'h000};
    vt[6]  = '{10'h3C0, 10'h3C0, 10'h000, 8'h40, 8'h00, 12'hB80, 12'h000};
    vt[7]  = '{10'h000, 10'h080, 10'h080, 8'h40, 8'h40, 12'h000, 12'h200};
    vt[8]  = '{10'h000, 10'h001, 10'h000, 8'h7F, 8'h7F, 12'h003, 12'h003};
    vt[9]  = '{10'h000, 10'h001, 10'h000, 8'h81, 8'h81, 12'hFFC, 12'hFFC};
    vt[10] = '{10'h080, 10'h080, 10'h000, 8'h00, 8'h7F, 12'h000, 12'h7FF};
    vt[11] = '{10'h080, 10'h080, 10'h000, 8'h81, 8'h81, 12'h800, 12'h800};

    // Reset state.
    do_reset();
    check("rst_o_valid", (NT*TW)'(o_valid), '0);
    check("rst_o_data_I", (NT*TW)'(o_data_I), '0);
    check("rst_o_data_Q", (NT*TW)'(o_data_Q), '0);
    check("rst_taps_I", o_taps_I, one_tap(MID, 10'h080));
    check("rst_taps_Q", o_taps_Q, '0);

    impulse(10);

    // Vector table: load taps, stream a constant sample, check once full.
    for (int v = 0; v < 12; v++) begin
      soft_clear();
      for (int k = 0; k < NT; k++) ti[k*TW +: TW] = (k == MID) ? vt[v].t_mid_i : vt[v].t_all;
      tq = one_tap(MID, vt[v].t_mid_q);
      load(ti, tq, 1'b0);
      check("load_taps_I", o_taps_I, ti);
      check("load_taps_Q", o_taps_Q, tq);
      for (int n = 0; n < 2*NT + 2; n++) begin
        send(vt[v].xi, vt[v].xq, (n >= NT - 1), vt[v].ei, vt[v].eq);
        if (v % 2 == 1) idle(1);
      end
      idle(1);
      drain();
    end

    // LMS step with mu=0, a second step, freeze and load priority.
    do_reset();
    impulse(6);
    err_upd(8'h40, 8'h00, 4'd0, 1'b1);
    check("lms_mu0_taps_I", o_taps_I, one_tap(MID, 10'h060));
    check("lms_mu0_taps_Q", o_taps_Q, '0);
    err_upd(8'h40, 8'h00, 4'd0, 1'b1);
    check("lms_second_taps_I", o_taps_I, one_tap(MID, 10'h040));
    err_upd(8'h40, 8'h00, 4'd0, 1'b0);
    check("freeze_taps_I", o_taps_I, one_tap(MID, 10'h040));
    check("freeze_taps_Q", o_taps_Q, '0);
    for (int k = 0; k < NT; k++) begin
      ti[k*TW +: TW] = 10'(k*69 + 3);
      tq[k*TW +: TW] = 10'(1023 - k*37);
    end
    load(ti, tq, 1'b1);
    check("prio_taps_I", o_taps_I, ti);
    check("prio_taps_Q", o_taps_Q, tq);

    // LMS step with mu=2.
    do_reset();
    impulse(6);
    err_upd(8'h40, 8'h00, 4'd2, 1'b1);
    check("lms_mu2_taps_I", o_taps_I, one_tap(MID, 10'h078));

    // Quadrature error, then a negative error with mu=3.
    do_reset();
    impulse(6);
    err_upd(8'h00, 8'h40, 4'd0, 1'b1);
    check("lms_eq_taps_I", o_taps_I, one_tap(MID, 10'h080));
    check("lms_eq_taps_Q", o_taps_Q, one_tap(MID, 10'h3E0));
    err_upd(8'hC0, 8'h00, 4'd3, 1'b1);
    check("lms_neg_taps_I", o_taps_I, one_tap(MID, 10'h084));
    check("lms_neg_taps_Q", o_taps_Q, one_tap(MID, 10'h3E0));

    // Async reset in the middle of a continuous stream.
    do_reset();
    for (int k = 0; k < NT; k++) begin
      ti[k*TW +: TW] = 10'($urandom_range(0, 1023));
      tq[k*TW +: TW] = 10'($urandom_range(0, 1023));
    end
    load(ti, tq, 1'b0);
    for (int j = 0; j < 12; j++)
      send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0, 12'h000, 12'h000);
    @(posedge clk); #3;
    i_reset_n = 1'b0;
    #1;
    check("arst_o_valid", (NT*TW)'(o_valid), '0);
    check("arst_o_data_I", (NT*TW)'(o_data_I), '0);
    check("arst_o_data_Q", (NT*TW)'(o_data_Q), '0);
    check("arst_taps_I", o_taps_I, one_tap(MID, 10'h080));
    check("arst_taps_Q", o_taps_Q, '0);
    sb.delete();
    ph = 0;
    i_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    i_reset_n = 1'b1;
    hist_I.delete();
    hist_Q.delete();
    for (int j = 0; j < 14; j++) begin
      xi = 8'($urandom_range(0, 255));
      xq = 8'($urandom_range(0, 255));
      hist_I.push_back(xi);
      hist_Q.push_back(xq);
      ei = 12'h000;
      eq = 12'h000;
      if (j >= MID) begin
        ei = {{2{hist_I[j-MID][7]}}, hist_I[j-MID], 2'b00};
        eq = {{2{hist_Q[j-MID][7]}}, hist_Q[j-MID], 2'b00};
      end
      send(xi, xq, 1'b1, ei, eq);
    end
    idle(1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
